// File: rtl/i2c_master_engine.sv
`default_nettype none
// ============================================================================
// Module   : i2c_master_engine
// Brief    : Bit-level single-master I2C engine: START, 7-bit address + R/W,
//            N data bytes with ACK handling, STOP. Open-drain SCL/SDA enables.
// Revision : 1.0 - initial release
// ============================================================================
module i2c_master_engine #(
    parameter int DIV_W = 32
) (
    input  logic             pclk,
    input  logic             rst,
    input  logic [DIV_W-1:0] clk_div,
    input  logic             start,
    input  logic             rw,
    input  logic [6:0]       slave_addr,
    input  logic [7:0]       byte_count,
    input  logic [7:0]       tx_data,
    input  logic             tx_empty,
    output logic             tx_r_ena,
    input  logic             rx_full,
    output logic [7:0]       rx_data,
    output logic             rx_w_ena,
    input  logic             sda_in,
    output logic             scl_out,
    output logic             sda_out,
    output logic             busy,
    output logic             done,
    output logic             nack
);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_START    = 4'd1,
        S_ADDR     = 4'd2,
        S_ADDR_ACK = 4'd3,
        S_WR_BYTE  = 4'd4,
        S_WR_ACK   = 4'd5,
        S_RD_BYTE  = 4'd6,
        S_RD_ACK   = 4'd7,
        S_STOP     = 4'd8
    } state_t;

    localparam logic [DIV_W-1:0] c_one = {{(DIV_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    state_t           w_next;
    logic [DIV_W-1:0] r_qlen;
    logic [DIV_W-1:0] r_qcnt;
    logic [DIV_W-1:0] w_qin;
    logic [1:0]       r_phase;
    logic [2:0]       r_bit;
    logic [7:0]       r_shift;
    logic [7:0]       r_remaining;
    logic             r_rw;
    logic             r_ack_smp;
    logic             r_nack_pend;
    logic             r_loaded;
    logic             r_pushed;
    logic             r_done;
    logic             r_nack;
    logic             w_accept;
    logic             w_tx_stall;
    logic             w_tx_pop;
    logic             w_rx_stall;
    logic             w_rx_push;
    logic             w_hold;
    logic             w_phase_end;
    logic             w_slot_end;
    logic             w_last_bit;
    logic             w_last_byte;

    assign w_qin       = (clk_div == '0) ? c_one : clk_div;
    assign w_accept    = (r_state == S_IDLE) && start && !r_done;

    // Byte-start stalls freeze the quarter counter, which keeps SCL low in P0.
    assign w_tx_stall  = (r_state == S_WR_BYTE) && !r_loaded && tx_empty;
    assign w_tx_pop    = (r_state == S_WR_BYTE) && !r_loaded && !tx_empty;
    assign w_rx_stall  = (r_state == S_RD_ACK) && !r_pushed && rx_full;
    assign w_rx_push   = (r_state == S_RD_ACK) && !r_pushed && !rx_full;
    assign w_hold      = w_tx_stall || w_rx_stall;

    assign w_phase_end = (r_qcnt == (r_qlen - c_one)) && !w_hold;
    assign w_slot_end  = w_phase_end && (r_phase == 2'd3);
    assign w_last_bit  = (r_bit == 3'd7);
    assign w_last_byte = (r_remaining <= 8'd1);

    assign busy     = (r_state != S_IDLE);
    assign done     = r_done;
    assign nack     = r_nack;
    assign tx_r_ena = w_tx_pop;
    assign rx_w_ena = w_rx_push;
    assign rx_data  = w_rx_push ? r_shift : 8'h00;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:     if (w_accept) w_next = S_START;
            S_START:    if (w_slot_end) w_next = S_ADDR;
            S_ADDR:     if (w_slot_end && w_last_bit) w_next = S_ADDR_ACK;
            S_ADDR_ACK: begin
                if (w_slot_end) begin
                    if (r_ack_smp || (r_remaining == 8'd0)) w_next = S_STOP;
                    else if (r_rw)                          w_next = S_RD_BYTE;
                    else                                    w_next = S_WR_BYTE;
                end
            end
            S_WR_BYTE:  if (w_slot_end && w_last_bit) w_next = S_WR_ACK;
            S_WR_ACK: begin
                if (w_slot_end) w_next = (r_ack_smp || w_last_byte) ? S_STOP : S_WR_BYTE;
            end
            S_RD_BYTE:  if (w_slot_end && w_last_bit) w_next = S_RD_ACK;
            S_RD_ACK: begin
                if (w_slot_end) w_next = w_last_byte ? S_STOP : S_RD_BYTE;
            end
            S_STOP:     if (w_slot_end) w_next = S_IDLE;
            default:    w_next = S_IDLE;
        endcase
    end

    always_comb begin
        scl_out = 1'b1;
        sda_out = 1'b1;
        case (r_state)
            S_IDLE: begin
                scl_out = 1'b1;
                sda_out = 1'b1;
            end
            S_START: begin
                sda_out = ~r_phase[1];
            end
            S_ADDR: begin
                scl_out = r_phase[1];
                sda_out = r_shift[7];
            end
            S_WR_BYTE: begin
                // Keep SDA released while waiting for data; show the new MSB on the pop cycle.
                scl_out = r_phase[1];
                sda_out = r_loaded ? r_shift[7] : (tx_empty ? 1'b1 : tx_data[7]);
            end
            S_ADDR_ACK, S_WR_ACK, S_RD_BYTE: begin
                scl_out = r_phase[1];
            end
            S_RD_ACK: begin
                scl_out = r_phase[1];
                sda_out = w_rx_stall ? 1'b1 : w_last_byte;
            end
            S_STOP: begin
                scl_out = (r_phase != 2'd0);
                sda_out = (r_phase == 2'd3);
            end
            default: begin
                scl_out = 1'b1;
                sda_out = 1'b1;
            end
        endcase
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_qlen      <= c_one;
            r_qcnt      <= '0;
            r_phase     <= 2'd0;
            r_bit       <= 3'd0;
            r_shift     <= 8'h00;
            r_remaining <= 8'h00;
            r_rw        <= 1'b0;
            r_ack_smp   <= 1'b0;
            r_nack_pend <= 1'b0;
            r_loaded    <= 1'b0;
            r_pushed    <= 1'b0;
            r_done      <= 1'b0;
            r_nack      <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= (r_state == S_STOP) && w_slot_end;
            r_nack  <= (r_state == S_STOP) && w_slot_end && r_nack_pend;

            if (w_accept) begin
                r_rw        <= rw;
                r_shift     <= {slave_addr, rw};
                r_remaining <= byte_count;
                r_nack_pend <= 1'b0;
                r_qlen      <= w_qin;
                r_qcnt      <= '0;
                r_phase     <= 2'd0;
                r_bit       <= 3'd0;
            end else if (r_state != S_IDLE) begin
                // The divider is re-sampled only at phase boundaries.
                if (w_phase_end) begin
                    r_qcnt  <= '0;
                    r_qlen  <= w_qin;
                    r_phase <= r_phase + 2'd1;
                end else if (!w_hold) begin
                    r_qcnt <= r_qcnt + c_one;
                end

                if (w_slot_end) begin
                    r_bit <= (w_next != r_state) ? 3'd0 : r_bit + 3'd1;
                end

                if (w_phase_end && (r_phase == 2'd2)) begin
                    r_ack_smp <= sda_in;
                end

                if (w_tx_pop) begin
                    r_shift <= tx_data;
                end else if (w_slot_end && ((r_state == S_ADDR) || (r_state == S_WR_BYTE))) begin
                    r_shift <= {r_shift[6:0], 1'b0};
                end else if (w_phase_end && (r_phase == 2'd2) && (r_state == S_RD_BYTE)) begin
                    r_shift <= {r_shift[6:0], sda_in};
                end

                if (w_tx_pop)                r_loaded <= 1'b1;
                else if (w_next != r_state)  r_loaded <= 1'b0;

                if (w_rx_push)               r_pushed <= 1'b1;
                else if (w_next != r_state)  r_pushed <= 1'b0;

                if (w_slot_end && (r_remaining != 8'd0) &&
                    (((r_state == S_WR_ACK) && !r_ack_smp) || (r_state == S_RD_ACK))) begin
                    r_remaining <= r_remaining - 8'd1;
                end

                if (w_slot_end && r_ack_smp &&
                    ((r_state == S_ADDR_ACK) || (r_state == S_WR_ACK))) begin
                    r_nack_pend <= 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_i2c_master_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2c_master_engine
// Brief    : Directed self-checking bench with a small behavioural I2C slave.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_master_engine;

    localparam int DIV_W = 32;

    logic             pclk = 1'b0;
    logic             rst = 1'b1;
    logic [DIV_W-1:0] clk_div = 1;
    logic             start = 1'b0;
    logic             rw = 1'b0;
    logic [6:0]       slave_addr = 7'h00;
    logic [7:0]       byte_count = 8'h00;
    logic [7:0]       tx_data = 8'h00;
    logic             tx_empty = 1'b1;
    logic             tx_r_ena;
    logic             rx_full = 1'b0;
    logic [7:0]       rx_data;
    logic             rx_w_ena;
    logic             sda_in;
    logic             scl_out;
    logic             sda_out;
    logic             busy;
    logic             done;
    logic             nack;

    logic             sl_drv = 1'b0;
    logic             sl_addr_ack = 1'b1;
    logic [7:0]       sl_rd [0:3];
    int               sl_rd_n = 0;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    logic        prev_scl = 1'b1;
    logic        prev_sda = 1'b1;
    logic        prev_busy = 1'b0;
    int          sl_bitn = 0;
    int          sl_frame = 0;
    logic [0:63] cap = '0;
    int          ncap = 0;
    int          n_tx = 0;
    int          n_rx = 0;
    int          n_done = 0;
    int          n_nack = 0;
    int          n_nack_alone = 0;
    int          n_both = 0;
    int          t_busy = 0;
    int          t_done = 0;
    int          low_run = 0;
    int          low_max = 0;
    logic [7:0]  rx_log [0:3];

    assign sda_in = sda_out & ~sl_drv;

    i2c_master_engine #(.DIV_W(DIV_W)) dut (
        .pclk       (pclk),
        .rst        (rst),
        .clk_div    (clk_div),
        .start      (start),
        .rw         (rw),
        .slave_addr (slave_addr),
        .byte_count (byte_count),
        .tx_data    (tx_data),
        .tx_empty   (tx_empty),
        .tx_r_ena   (tx_r_ena),
        .rx_full    (rx_full),
        .rx_data    (rx_data),
        .rx_w_ena   (rx_w_ena),
        .sda_in     (sda_in),
        .scl_out    (scl_out),
        .sda_out    (sda_out),
        .busy       (busy),
        .done       (done),
        .nack       (nack)
    );

    initial forever #5 pclk = ~pclk;
    initial forever begin
        @(posedge pclk);
        cyc++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Slave pull-down for the bit that follows an SCL falling edge.
    function automatic logic slave_drive(input int frame, input int bitn);
        if (frame == 0) return (bitn == 8) && sl_addr_ack;
        if (cap[7]) begin
            if ((frame <= sl_rd_n) && (bitn < 8)) return ~sl_rd[frame-1][7-bitn];
            return 1'b0;
        end
        return (bitn == 8);
    endfunction

    // Bus monitor and slave responder, sampled on the inactive edge.
    initial forever begin
        logic bus_sda;
        @(negedge pclk);
        bus_sda = sda_out & ~sl_drv;
        if (busy && !prev_busy) begin
            t_busy = cyc; ncap = 0; n_tx = 0; n_rx = 0; n_done = 0; n_nack = 0;
            low_run = 0; low_max = 0;
        end
        if (tx_r_ena) n_tx++;
        if (rx_w_ena) begin
            if (n_rx < 4) rx_log[n_rx] = rx_data;
            n_rx++;
        end
        if (tx_r_ena && rx_w_ena) n_both++;
        if (done) begin n_done++; t_done = cyc; end
        if (nack) begin n_nack++; if (!done) n_nack_alone++; end
        if (!scl_out) begin
            low_run++;
            if (low_run > low_max) low_max = low_run;
        end else begin
            low_run = 0;
        end
        if (rst) begin
            sl_drv = 1'b0; sl_bitn = 0; sl_frame = 0;
        end else if (prev_scl && scl_out && prev_sda && !bus_sda) begin
            sl_drv = 1'b0; sl_bitn = 0; sl_frame = 0;
        end else if (!prev_scl && scl_out) begin
            if (ncap < 64) cap[ncap] = bus_sda;
            ncap++;
            sl_bitn++;
        end else if (prev_scl && !scl_out) begin
            if (sl_bitn >= 9) begin sl_bitn = 0; sl_frame++; end
            sl_drv = slave_drive(sl_frame, sl_bitn);
        end
        prev_scl  = scl_out;
        prev_sda  = sda_out & ~sl_drv;
        prev_busy = busy;
    end

    task automatic pulse_start(input logic [DIV_W-1:0] q, input logic [6:0] a,
                               input logic r, input logic [7:0] n);
        @(posedge pclk); #1;
        clk_div = q; slave_addr = a; rw = r; byte_count = n; start = 1'b1;
        @(posedge pclk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int k;
        k = 0;
        while (!done && (k < 5000)) begin
            @(negedge pclk);
            k++;
        end
        check({tag, "_done_seen"}, done, 1);
        check({tag, "_busy_at_done"}, busy, 0);
        #1;
    endtask

    initial begin
        // Reset values, with start held high under reset.
        start = 1'b1;
        repeat (3) @(posedge pclk);
        #1;
        check("rst_scl", scl_out, 1);
        check("rst_sda", sda_out, 1);
        check("rst_busy", busy, 0);
        check("rst_strobes", {tx_r_ena, rx_w_ena, done, nack}, 0);
        check("rst_rx_data", rx_data, 0);
        rst = 1'b0; start = 1'b0;
        @(posedge pclk); #1;
        check("rst_start_ignored", busy, 0);

        // Write 0xA5 to 0x50, Q=2.
        sl_addr_ack = 1'b1; tx_empty = 1'b0; tx_data = 8'hA5;
        pulse_start(2, 7'h50, 1'b0, 8'd1);
        check("wr_busy_after_start", busy, 1);
        wait_done("wr");
        check("wr_cycles", t_done - t_busy, 160);
        check("wr_addr_bits", cap[0:7], 8'hA0);
        check("wr_addr_ack", cap[8], 0);
        check("wr_data_bits", cap[9:16], 8'hA5);
        check("wr_tx_pops", n_tx, 1);
        check("wr_nack", n_nack, 0);

        // Read 0x12, 0x34 from 0x3C, Q=1.
        tx_empty = 1'b1;
        sl_rd[0] = 8'h12; sl_rd[1] = 8'h34; sl_rd_n = 2;
        pulse_start(1, 7'h3C, 1'b1, 8'd2);
        wait_done("rd");
        check("rd_cycles", t_done - t_busy, 116);
        check("rd_addr_bits", cap[0:7], 8'h79);
        check("rd_pushes", n_rx, 2);
        check("rd_byte0", rx_log[0], 8'h12);
        check("rd_byte1", rx_log[1], 8'h34);
        check("rd_master_ack", cap[17], 0);
        check("rd_master_nack", cap[26], 1);
        check("rd_tx_pops", n_tx, 0);
        // Start arriving in the done cycle must be ignored.
        start = 1'b1;
        @(posedge pclk); #1;
        start = 1'b0;
        check("done_start_ignored", busy, 0);

        // Address NACK.
        sl_addr_ack = 1'b0; tx_empty = 1'b0; tx_data = 8'h55;
        pulse_start(1, 7'h21, 1'b0, 8'd3);
        wait_done("anack");
        check("anack_cycles", t_done - t_busy, 44);
        check("anack_sampled", cap[8], 1);
        check("anack_nack", n_nack, 1);
        check("anack_strobes", n_tx + n_rx, 0);

        // TX underflow stall of 20 cycles, Q=1.
        sl_addr_ack = 1'b1; tx_empty = 1'b1; tx_data = 8'h3C;
        pulse_start(1, 7'h11, 1'b0, 8'd1);
        repeat (60) @(posedge pclk);
        #1;
        check("stall_scl_low", scl_out, 0);
        check("stall_sda_released", sda_out, 1);
        check("stall_no_pop", n_tx, 0);
        tx_empty = 1'b0;
        wait_done("stall");
        check("stall_cycles", t_done - t_busy, 100);
        check("stall_low_run", low_max, 22);
        check("stall_tx_pops", n_tx, 1);
        check("stall_addr_bits", cap[0:7], 8'h22);
        check("stall_data_bits", cap[9:16], 8'h3C);

        // Reset during RD_BYTE bit 4, Q=2.
        tx_empty = 1'b1;
        sl_rd[0] = 8'hF0; sl_rd_n = 1;
        pulse_start(2, 7'h3C, 1'b1, 8'd1);
        repeat (114) @(posedge pclk);
        #1;
        check("mid_busy", busy, 1);
        check("mid_scl_low", scl_out, 0);
        rst = 1'b1;
        @(posedge pclk); #1;
        rst = 1'b0;
        check("mid_rst_scl", scl_out, 1);
        check("mid_rst_sda", sda_out, 1);
        check("mid_rst_busy", busy, 0);
        repeat (40) @(posedge pclk);
        #1;
        check("mid_rst_no_push", n_rx, 0);
        check("mid_rst_no_done", n_done, 0);

        // Divider clamp: clk_div=0 probe.
        sl_addr_ack = 1'b1;
        pulse_start(0, 7'h2A, 1'b0, 8'd0);
        wait_done("probe");
        check("probe_cycles", t_done - t_busy, 44);
        check("probe_nack", n_nack, 0);
        check("probe_strobes", n_tx + n_rx, 0);

        check("nack_without_done", n_nack_alone, 0);
        check("strobe_overlap", n_both, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
